count_ctrl: RTL and testbench
=============================

COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES SHALL default to 4 and set the consecutive stable synchronized cycles a button needs to be accepted; legal range 1..255.
REQ-002 Parameter PRESCALE SHALL default to 8 and set the clock cycles per count step while running; legal range 2..65535.
REQ-003 Port clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port btn_run  input  1  SHALL be the raw, asynchronous run/stop pushbutton, active-high.
REQ-006 Port btn_swap  input  1  SHALL be the raw, asynchronous swap-request pushbutton, active-high.
REQ-007 Port enable  output  1  SHALL be a registered one-cycle step pulse driving the downstream up/down counter's enable.
REQ-008 Port swap  output  1  SHALL be registered; it drives the downstream counter's swap and is high only in cycles where enable is high.
REQ-009 Port running  output  1  SHALL be high while the state machine is in RUN.

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-011 Each synchronized button SHALL have its own debounce counter and debounced level db.
- Counter clears whenever the synchronized value equals db.
- db takes the synchronized value once it has differed for DEBOUNCE_CYCLES consecutive cycles.
- Any shorter pulse is discarded.
REQ-012 A rising edge of a debounced button SHALL be a one-cycle internal event, one cycle after db rises.
- Total latency from a raw level change held stable to the event acting on state = 2 + DEBOUNCE_CYCLES + 1 cycles (7 at defaults).
REQ-013 The state machine SHALL have states IDLE and RUN (plus STEP under REQ-024).
- IDLE -> RUN on a run event.
- RUN -> IDLE on a run event.
- No other transitions.
REQ-014 In RUN, the prescaler SHALL count 0..PRESCALE-1 and wrap to 0.
- Each cycle it holds PRESCALE-1, enable is high in the next cycle.
- This gives exactly one enable pulse per PRESCALE cycles.
REQ-015 On entering RUN, the prescaler SHALL start at 0, so the first enable rises PRESCALE cycles after running rises.
REQ-016 On leaving RUN, the prescaler SHALL clear to 0 and no further enable is issued; a pulse already registered in that cycle completes.
REQ-017 A swap event SHALL set swap_pending in any state; repeated events while pending are absorbed (one swap only).
REQ-018 In each enable cycle, swap SHALL equal the swap_pending value sampled when the pulse was generated, and swap_pending SHALL clear in that cycle.
REQ-019 A swap event coinciding with the cycle that generates an enable pulse SHALL leave swap_pending set for the following step; set wins over clear.
REQ-020 Run and swap events in the same cycle SHALL both take effect independently.

Reset
REQ-021 While reset is high at a clock edge, the following SHALL be forced:
- state = IDLE; prescaler = 0; swap_pending = 0.
- Synchronizers, debounce counters and db levels = 0.
- enable = 0, swap = 0, running = 0.
REQ-022 Reset asserted mid-operation SHALL abort any pending swap, in-progress debounce or prescaler count with no further enable pulse.
REQ-023 A button held high through reset release SHALL debounce from 0 and produce one event after the REQ-012 latency.

Configuration
REQ-024 With macro COUNT_CTRL_STEP_EN defined, the following SHALL be added:
- Input port btn_step (raw, active-high), with REQ-010/011/012 conditioning.
- State STEP, entered from IDLE on a step event.
- STEP issues exactly one enable (with swap per REQ-018) next cycle, then returns to IDLE.
- Step events in RUN are ignored.
REQ-025 Without COUNT_CTRL_STEP_EN, port btn_step and state STEP SHALL be absent, and behaviour is exactly REQ-001..023.

Verification
REQ-026 Defaults; btn_run high 10 cycles from cycle 0 -> running rises at cycle 7; first enable at cycle 15; then enable every 8 cycles; swap stays 0.
REQ-027 btn_swap glitch 3 cycles high -> no swap ever; glitch 4 cycles high -> swap=1 with the next enable only.
REQ-028 Swap pressed while IDLE, run pressed later -> swap_pending held; first enable after RUN entry has swap=1; later ones swap=0.
REQ-029 Swap event in the same cycle the enable pulse is generated -> that enable has swap=0; the next enable (8 cycles later) has swap=1.
REQ-030 Reset pulsed 1 cycle while RUN with swap pending -> next cycle all outputs 0; no enable follows without a new run event.
REQ-031 COUNT_CTRL_STEP_EN defined, IDLE, one btn_step press -> exactly one enable pulse, running stays 0; the same press during RUN -> no extra enable.

Source files
------------

// File: rtl/count_ctrl_if.sv
// Button inputs and step outputs between count_ctrl and its surroundings.
// The btn_step signal exists only when COUNT_CTRL_STEP_EN is defined.
interface count_ctrl_if;
    logic btn_run;
    logic btn_swap;
`ifdef COUNT_CTRL_STEP_EN
    logic btn_step;
`endif
    logic enable;
    logic swap;
    logic running;

`ifdef COUNT_CTRL_STEP_EN
    modport master (output btn_run, btn_swap, btn_step, input enable, swap, running);
    modport slave  (input btn_run, btn_swap, btn_step, output enable, swap, running);
`else
    modport master (output btn_run, btn_swap, input enable, swap, running);
    modport slave  (input btn_run, btn_swap, output enable, swap, running);
`endif
endinterface

// File: rtl/count_ctrl.sv
// Run/stop and swap controller for a downstream up/down counter: debounced buttons, prescaled enable.
// Optional single-step button and STEP state are built when COUNT_CTRL_STEP_EN is defined.
module count_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PRESCALE        = 8
) (
    input  logic         clock,
    input  logic         reset,
    count_ctrl_if.slave  bus
);

`ifdef COUNT_CTRL_STEP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // button index: 0 = run, 1 = swap, 2 = step
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] db;
    logic [NB-1:0] db_d;
    logic [NB-1:0] ev;
    logic [7:0]    db_cnt [NB];

`ifdef COUNT_CTRL_STEP_EN
    assign raw = {bus.btn_step, bus.btn_swap, bus.btn_run};
`else
    assign raw = {bus.btn_swap, bus.btn_run};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            ev    <= '0;
            for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_d  <= db;
            ev    <= db & ~db_d;
            // db follows sync2 only after it has disagreed for DEBOUNCE_CYCLES samples in a row
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    logic ev_run;
    logic ev_swap;
    assign ev_run  = ev[0];
    assign ev_swap = ev[1];

`ifdef COUNT_CTRL_STEP_EN
    logic ev_step;
    assign ev_step = ev[2];
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic          pend;
    logic          pend_next;
    logic          gen;
    logic          enable_q;
    logic          swap_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            presc    <= '0;
            pend     <= 1'b0;
            enable_q <= 1'b0;
            swap_q   <= 1'b0;
        end else begin
            state    <= state_next;
            presc    <= presc_next;
            pend     <= pend_next;
            enable_q <= gen;
            swap_q   <= gen & pend;
        end
    end

    always_comb begin
        state_next = state;
        presc_next = '0;
        gen        = 1'b0;
        case (state)
            IDLE: begin
                if (ev_run) state_next = RUN;
`ifdef COUNT_CTRL_STEP_EN
                else if (ev_step) state_next = STEP;
`endif
            end
            RUN: begin
                // a stop request suppresses the pulse that would otherwise be generated now
                if (ev_run) begin
                    state_next = IDLE;
                end else begin
                    gen        = (presc == PW'(PRESCALE - 1));
                    presc_next = gen ? '0 : presc + PW'(1);
                end
            end
`ifdef COUNT_CTRL_STEP_EN
            STEP: begin
                gen        = 1'b1;
                state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
        // a new swap request wins over the clear caused by the pulse that consumes the old one
        pend_next = ev_swap | (pend & ~gen);
    end

    assign bus.enable  = enable_q;
    assign bus.swap    = swap_q;
    assign bus.running = (state == RUN);

endmodule

// File: tb/tb_count_ctrl.sv
// Directed and random bench for count_ctrl against a window/modulo behavioural model.
module tb_count_ctrl;
    localparam int D = 4;
    localparam int P = 8;
`ifdef COUNT_CTRL_STEP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    count_ctrl_if bus();

    count_ctrl #(.DEBOUNCE_CYCLES(D), .PRESCALE(P)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // model state: last D synchronized samples per button, debounced level, event pipeline
    bit m_s1 [NB];
    bit m_s2 [NB];
    bit m_db [NB];
    bit m_rose [NB];
    bit m_ev [NB];
    bit hist [NB][D];
    bit m_running, m_step, m_pend, m_en, m_sw;
    int m_k;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int b, input bit v);
        case (b)
            0: bus.btn_run = v;
            1: bus.btn_swap = v;
`ifdef COUNT_CTRL_STEP_EN
            2: bus.btn_step = v;
`endif
            default: ;
        endcase
    endtask

    task automatic model_edge();
        bit raw [NB];
        bit gen, nrun, nstep, flip;
        raw[0] = bus.btn_run;
        raw[1] = bus.btn_swap;
`ifdef COUNT_CTRL_STEP_EN
        raw[2] = bus.btn_step;
`endif
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_rose[b] = 0; m_ev[b] = 0;
                for (int i = 0; i < D; i++) hist[b][i] = 0;
            end
            m_running = 0; m_step = 0; m_pend = 0; m_en = 0; m_sw = 0; m_k = 0;
            return;
        end
        gen   = (m_running && (m_k % P == P - 1) && !m_ev[0]) || m_step;
        nrun  = m_step ? 1'b0 : (m_running ^ m_ev[0]);
        nstep = 1'b0;
`ifdef COUNT_CTRL_STEP_EN
        nstep = !m_running && !m_step && m_ev[2] && !m_ev[0];
`endif
        m_k       = (m_running && nrun) ? m_k + 1 : 0;
        m_running = nrun;
        m_step    = nstep;
        m_en      = gen;
        m_sw      = gen && m_pend;
        m_pend    = m_ev[1] || (m_pend && !gen);
        for (int b = 0; b < NB; b++) begin
            for (int i = D - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
            hist[b][0] = m_s2[b];
            flip = 1;
            for (int i = 0; i < D; i++) if (hist[b][i] == m_db[b]) flip = 0;
            if (flip) m_db[b] = !m_db[b];
            m_ev[b]   = m_rose[b];
            m_rose[b] = flip && m_db[b];
            m_s2[b]   = m_s1[b];
            m_s1[b]   = raw[b];
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check("enable", bus.enable, m_en);
        check("swap", bus.swap, m_sw);
        check("running", bus.running, m_running);
    endtask

    task automatic press(input int b, input int len);
        set_btn(b, 1'b1);
        repeat (len) tick();
        set_btn(b, 1'b0);
    endtask

    task automatic wait_enable(input string tag, output bit sw);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.enable && n < 40);
        check({tag, "_seen"}, bus.enable, 1'b1);
        sw = bus.swap;
    endtask

    initial begin
        bit sw;
        int n_en, n_sw, n, hold [NB];
        bus.btn_run  = 0;
        bus.btn_swap = 0;
`ifdef COUNT_CTRL_STEP_EN
        bus.btn_step = 0;
`endif
        reset = 1;
        repeat (3) tick();
        check("rst_enable", bus.enable, 1'b0);
        check("rst_swap", bus.swap, 1'b0);
        check("rst_running", bus.running, 1'b0);

        // run pressed 10 cycles from cycle 0
        reset = 0;
        bus.btn_run = 1;
        for (int c = 0; c <= 23; c++) begin
            tick();
            if (c == 9) bus.btn_run = 0;
            if (c == 6) check("run_c6", bus.running, 1'b0);
            if (c == 7) check("run_c7", bus.running, 1'b1);
            if (c == 14) check("en_c14", bus.enable, 1'b0);
            if (c == 15) check("en_c15", bus.enable, 1'b1);
            if (c == 15) check("sw_c15", bus.swap, 1'b0);
            if (c == 22) check("en_c22", bus.enable, 1'b0);
            if (c == 23) check("en_c23", bus.enable, 1'b1);
        end

        // 3-cycle glitch discarded, 4-cycle press accepted
        press(1, 3);
        n_sw = 0;
        repeat (30) begin tick(); if (bus.swap) n_sw++; end
        check("glitch3_noswap", n_sw != 0, 1'b0);
        press(1, 4);
        repeat (4) tick();
        wait_enable("glitch4_a", sw);
        check("glitch4_first_sw", sw, 1'b1);
        wait_enable("glitch4_b", sw);
        check("glitch4_second_sw", sw, 1'b0);

        // swap event lands in the cycle a pulse is generated
        n = 0;
        while (m_k % P != 0 && n < 20) begin tick(); n++; end
        check("align_found", m_k % P == 0, 1'b1);
        press(1, 5);
        wait_enable("coinc_a", sw);
        check("coinc_first_sw", sw, 1'b0);
        wait_enable("coinc_b", sw);
        check("coinc_second_sw", sw, 1'b1);

        // reset while running with a swap pending
        press(1, 5);
        repeat (3) tick();
        reset = 1;
        tick();
        reset = 0;
        check("rstmid_enable", bus.enable, 1'b0);
        check("rstmid_swap", bus.swap, 1'b0);
        check("rstmid_running", bus.running, 1'b0);
        n_en = 0;
        repeat (40) begin tick(); if (bus.enable) n_en++; end
        check("rstmid_noenable", n_en != 0, 1'b0);

        // swap armed while idle, carried into the first step of the next run
        press(1, 5);
        repeat (20) tick();
        press(0, 5);
        wait_enable("idleswap_a", sw);
        check("idleswap_first_sw", sw, 1'b1);
        wait_enable("idleswap_b", sw);
        check("idleswap_second_sw", sw, 1'b0);

        // run held through reset release
        reset = 1;
        bus.btn_run = 1;
        repeat (3) tick();
        reset = 0;
        for (int c = 0; c <= 7; c++) begin
            tick();
            if (c == 6) check("hold_c6", bus.running, 1'b0);
            if (c == 7) check("hold_c7", bus.running, 1'b1);
        end
        bus.btn_run = 0;
        repeat (10) tick();

`ifdef COUNT_CTRL_STEP_EN
        reset = 1;
        repeat (2) tick();
        reset = 0;
        press(2, 5);
        n_en = 0;
        n = 0;
        repeat (25) begin tick(); if (bus.enable) n_en++; if (bus.running) n++; end
        check("step_one_enable", n_en == 1, 1'b1);
        check("step_not_running", n != 0, 1'b0);
        press(0, 5);
        repeat (12) tick();
        press(2, 5);
        repeat (30) tick();
`endif

        // random button activity with occasional resets
        for (int b = 0; b < NB; b++) hold[b] = 0;
        repeat (2500) begin
            for (int b = 0; b < NB; b++) begin
                if (hold[b] == 0) begin
                    set_btn(b, 1'($urandom_range(0, 1)));
                    hold[b] = $urandom_range(1, 14);
                end else begin
                    hold[b]--;
                end
            end
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
